// File: rtl/mesi_pkg.sv
// Shared encodings for the MESI snoop responder: line states, bus ops, FSM states.
package mesi_pkg;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] RD_MISS = 2'b00;
  localparam logic [1:0] WR_MISS = 2'b01;
  localparam logic [1:0] INVAL   = 2'b10;
  localparam logic [1:0] RSVD    = 2'b11;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'b00,
    FSM_LOOKUP = 2'b01,
    FSM_WB     = 2'b10,
    FSM_RESP   = 2'b11
  } fsm_t;

endpackage

// File: rtl/mesi_line_array.sv
// Direct-mapped tag/state storage: one synchronous write port, one combinational read port.
module mesi_line_array #(
  parameter int LINES = 4,
  parameter int TAG_W = 8,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [1:0]       wr_state,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [TAG_W-1:0] rd_tag,
  output logic [1:0]       rd_state
);

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [1:0]       st_mem  [LINES];

  // Reset clears every line to I with tag 0; otherwise a single write per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        tag_mem[i] <= '0;
        st_mem[i]  <= 2'b00;
      end
    end else if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      st_mem[wr_idx]  <= wr_state;
    end
  end

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_state = st_mem[rd_idx];

endmodule

// File: rtl/mesi_snoop_responder.sv
// Bus-side MESI snoop controller: looks up the local line, applies the snoop
// transition, writes back Modified data when needed and strobes a response.
//
// state  | meaning
// IDLE   | ready for a snoop or a local fill
// LOOKUP | latched snoop compares against the array and updates it
// WB     | writeback of a Modified line outstanding to memory
// RESP   | response scheduled; resp_valid strobes on the following cycle
module mesi_snoop_responder
  import mesi_pkg::*;
#(
  parameter int LINES = 4,
  parameter int TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_valid,
  output logic                     bus_ready,
  input  logic [1:0]               bus_op,
  input  logic [TAG_W-1:0]         bus_tag,
  output logic                     resp_valid,
  output logic                     resp_shared,
  output logic                     wb_req,
  output logic [TAG_W-1:0]         wb_tag,
  input  logic                     wb_ack,
  input  logic                     fill_valid,
  input  logic [$clog2(LINES)-1:0] fill_idx,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [1:0]               fill_state,
  output logic                     fill_ready,
  output logic                     protocol_err
);

  localparam int IDX_W = $clog2(LINES);

  fsm_t             state;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             shared_q;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       wr_state;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_state;
  logic             hit;
  logic             wb_done;

  assign line_idx = tag_q[IDX_W-1:0];
  assign hit      = (rd_tag == tag_q) && (rd_state != ST_I);
  // Only an ack seen while the request is actually visible completes the writeback.
  assign wb_done  = (state == FSM_WB) && wb_req && wb_ack;

  // Ready strobes are state decodes, forced low while reset is held.
  assign bus_ready  = rst_n && (state == FSM_IDLE);
  assign fill_ready = rst_n && (state == FSM_IDLE);

  mesi_line_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_state (wr_state),
    .rd_idx   (line_idx),
    .rd_tag   (rd_tag),
    .rd_state (rd_state)
  );

  // Array write mux: local fill in IDLE, snoop update in LOOKUP or on writeback ack.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = fill_idx;
    wr_tag   = fill_tag;
    wr_state = fill_state;
    case (state)
      FSM_IDLE: begin
        wr_en = fill_valid;
      end
      FSM_LOOKUP: begin
        wr_idx = line_idx;
        wr_tag = tag_q;
        if (hit) begin
          case (op_q)
            RD_MISS: begin
              if (rd_state != ST_M) begin
                wr_en    = 1'b1;
                wr_state = ST_S;
              end
            end
            WR_MISS: begin
              if (rd_state != ST_M) begin
                wr_en    = 1'b1;
                wr_state = ST_I;
              end
            end
            INVAL: begin
              wr_en    = 1'b1;
              wr_state = ST_I;
            end
            default: ;
          endcase
        end
      end
      FSM_WB: begin
        wr_idx   = line_idx;
        wr_tag   = tag_q;
        wr_en    = wb_done;
        wr_state = (op_q == RD_MISS) ? ST_S : ST_I;
      end
      default: ;
    endcase
  end

  // Control FSM with registered response, writeback and error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FSM_IDLE;
      op_q         <= RD_MISS;
      tag_q        <= '0;
      shared_q     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_shared  <= 1'b0;
      wb_req       <= 1'b0;
      wb_tag       <= '0;
      protocol_err <= 1'b0;
    end else begin
      resp_valid  <= (state == FSM_RESP);
      resp_shared <= (state == FSM_RESP) && shared_q;
      wb_req      <= (state == FSM_WB) && !wb_done;
      case (state)
        FSM_IDLE: begin
          if (bus_valid) begin
            op_q  <= bus_op;
            tag_q <= bus_tag;
            state <= FSM_LOOKUP;
          end
        end
        FSM_LOOKUP: begin
          shared_q <= 1'b0;
          state    <= FSM_RESP;
          if (op_q == RSVD) begin
            protocol_err <= 1'b1;
          end else if (hit) begin
            if (rd_state == ST_M) begin
              if (op_q == INVAL) begin
                protocol_err <= 1'b1;
              end else begin
                wb_tag <= tag_q;
                state  <= FSM_WB;
              end
            end else begin
              if (op_q == INVAL && rd_state == ST_E) protocol_err <= 1'b1;
              if (op_q == RD_MISS) shared_q <= 1'b1;
            end
          end
        end
        FSM_WB: begin
          if (wb_done) begin
            shared_q <= (op_q == RD_MISS);
            state    <= FSM_RESP;
          end
        end
        FSM_RESP: begin
          state <= FSM_IDLE;
        end
        default: state <= FSM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for mesi_snoop_responder with a response scoreboard.
module tb_mesi_snoop_responder;
  import mesi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_valid = 1'b0;
  logic       bus_ready;
  logic [1:0] bus_op = 2'b00;
  logic [7:0] bus_tag = 8'h00;
  logic       resp_valid;
  logic       resp_shared;
  logic       wb_req;
  logic [7:0] wb_tag;
  logic       wb_ack = 1'b0;
  logic       fill_valid = 1'b0;
  logic [1:0] fill_idx = 2'd0;
  logic [7:0] fill_tag = 8'h00;
  logic [1:0] fill_state = 2'b00;
  logic       fill_ready;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];
  logic wb_seen = 1'b0;

  mesi_snoop_responder #(.LINES(4), .TAG_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_op       (bus_op),
    .bus_tag      (bus_tag),
    .resp_valid   (resp_valid),
    .resp_shared  (resp_shared),
    .wb_req       (wb_req),
    .wb_tag       (wb_tag),
    .wb_ack       (wb_ack),
    .fill_valid   (fill_valid),
    .fill_idx     (fill_idx),
    .fill_tag     (fill_tag),
    .fill_state   (fill_state),
    .fill_ready   (fill_ready),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got shared=%0d with no expected response", resp_shared);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (resp_shared !== e) begin
          errors++;
          $display("FAIL resp_shared got %0d expected %0d", resp_shared, e);
        end
      end
    end
    if (wb_req) wb_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_fill(input logic [1:0] idx, input logic [7:0] tag, input logic [1:0] st);
    fill_valid = 1'b1;
    fill_idx   = idx;
    fill_tag   = tag;
    fill_state = st;
    tick();
    fill_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus_ready) chk("bus_ready_timeout", 32'(bus_ready), 32'd1);
  endtask

  // Presents a snoop until accepted; returns just after the accepting edge.
  task automatic snoop(input logic [1:0] op, input logic [7:0] tag);
    wait_ready();
    bus_valid = 1'b1;
    bus_op    = op;
    bus_tag   = tag;
    tick();
    bus_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;

    // Reset state.
    tick();
    tick();
    chk("rst_bus_ready", 32'(bus_ready), 32'd0);
    chk("rst_fill_ready", 32'(fill_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_wb_req", 32'(wb_req), 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    chk("rst_protocol_err", 32'(protocol_err), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_bus_ready", 32'(bus_ready), 32'd1);
    chk("post_rst_fill_ready", 32'(fill_ready), 32'd1);

    // E line, read miss: shared, becomes S, no writeback, two-cycle latency.
    do_fill(2'd1, 8'h11, ST_E);
    wb_seen = 1'b0;
    exp_q.push_back(1'b1);
    snoop(RD_MISS, 8'h11);
    chk("t1_bus_ready_busy", 32'(bus_ready), 32'd0);
    wait_resp(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_line1_state", 32'(dut.u_array.st_mem[1]), 32'(ST_S));
    chk("t1_no_wb", 32'(wb_seen), 32'd0);

    // M line, write miss with slow ack.
    tick();
    do_fill(2'd2, 8'h22, ST_M);
    exp_q.push_back(1'b0);
    snoop(WR_MISS, 8'h22);
    tick();
    chk("t2_wb_req_not_yet", 32'(wb_req), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_wb_req_held", 32'(wb_req), 32'd1);
      chk("t2_wb_tag_held", 32'(wb_tag), 32'h22);
      chk("t2_no_resp_yet", 32'(resp_valid), 32'd0);
      tick();
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("t2_wb_req_drop", 32'(wb_req), 32'd0);
    wait_resp(n);
    chk("t2_ack_to_resp", 32'(n), 32'd1);
    chk("t2_line2_state", 32'(dut.u_array.st_mem[2]), 32'(ST_I));

    // Index alias miss leaves the S line untouched.
    tick();
    do_fill(2'd0, 8'h40, ST_S);
    exp_q.push_back(1'b0);
    snoop(RD_MISS, 8'h80);
    wait_resp(n);
    chk("t3_latency", 32'(n), 32'd2);
    chk("t3_line0_state", 32'(dut.u_array.st_mem[0]), 32'(ST_S));
    chk("t3_line0_tag", 32'(dut.u_array.tag_mem[0]), 32'h40);

    // Invalidate on M: no writeback, error flagged; reserved op keeps error and state.
    tick();
    do_fill(2'd3, 8'h13, ST_M);
    wb_seen = 1'b0;
    chk("t4_err_before", 32'(protocol_err), 32'd0);
    exp_q.push_back(1'b0);
    snoop(INVAL, 8'h13);
    wait_resp(n);
    chk("t4_err_set", 32'(protocol_err), 32'd1);
    chk("t4_line3_state", 32'(dut.u_array.st_mem[3]), 32'(ST_I));
    chk("t4_no_wb", 32'(wb_seen), 32'd0);
    tick();
    exp_q.push_back(1'b0);
    snoop(RSVD, 8'h11);
    wait_resp(n);
    chk("t4_rsvd_err", 32'(protocol_err), 32'd1);
    chk("t4_rsvd_line1", 32'(dut.u_array.st_mem[1]), 32'(ST_S));

    // Fill and snoop in the same IDLE cycle; a fill during LOOKUP is refused.
    tick();
    wait_ready();
    exp_q.push_back(1'b1);
    fill_valid = 1'b1;
    fill_idx   = 2'd1;
    fill_tag   = 8'h31;
    fill_state = ST_E;
    bus_valid  = 1'b1;
    bus_op     = RD_MISS;
    bus_tag    = 8'h31;
    tick();
    bus_valid  = 1'b0;
    fill_tag   = 8'h77;
    fill_state = ST_M;
    chk("t5_fill_ready_lookup", 32'(fill_ready), 32'd0);
    tick();
    fill_valid = 1'b0;
    wait_resp(n);
    chk("t5_resp_seen", 32'(resp_valid), 32'd1);
    chk("t5_line1_state", 32'(dut.u_array.st_mem[1]), 32'(ST_S));
    chk("t5_line1_tag", 32'(dut.u_array.tag_mem[1]), 32'h31);

    // Reset while a writeback is pending: no response, array and error cleared.
    tick();
    do_fill(2'd2, 8'h52, ST_M);
    snoop(RD_MISS, 8'h52);
    tick();
    tick();
    chk("t6_wb_req_up", 32'(wb_req), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_wb_req_drop", 32'(wb_req), 32'd0);
    chk("t6_bus_ready_rst", 32'(bus_ready), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_err_clear", 32'(protocol_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_line_state", 32'(dut.u_array.st_mem[i]), 32'(ST_I));
      chk("t6_line_tag", 32'(dut.u_array.tag_mem[i]), 32'd0);
    end
    chk("t6_bus_ready_idle", 32'(bus_ready), 32'd1);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
